grid_solve_ctrl: RTL

// Sequences one solve of the sudoku grid core per host request.
// - Accepts a request through a valid/ready handshake.
// - Clears the grid with a synchronous reset pulse, then pulses its start input.
// - Counts solve cycles and enforces an optional watchdog timeout.
// - Returns status and cycle count through a valid/ready response handshake.

---
 rtl/sudoku_ctrl_pkg.sv | 26 ++
 rtl/grid_solve_ctrl_sat_counter.sv | 39 +++
 rtl/grid_solve_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/sudoku_ctrl_pkg.sv
// Shared types for the sudoku solve controller.
//   solve_status_e : result code returned to the host with each response
//   ctrl_state_e   : one-hot controller state encoding
//   CNT_W_DEF      : default width of the timeout value and the cycle counter
package sudoku_ctrl_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    STATUS_SUCCESS = 2'd0,
    STATUS_FAILURE = 2'd1,
    STATUS_TIMEOUT = 2'd2,
    STATUS_ABORTED = 2'd3
  } solve_status_e;

  // One-hot, matching the state style used inside the grid core.
  typedef enum logic [5:0] {
    ST_INIT    = 6'b000001,
    ST_IDLE    = 6'b000010,
    ST_CLEAR   = 6'b000100,
    ST_ARM     = 6'b001000,
    ST_RUN     = 6'b010000,
    ST_RESPOND = 6'b100000
  } ctrl_state_e;

endpackage

// File: rtl/grid_solve_ctrl_sat_counter.sv
// Saturating up-counter.
//   clock  : clock, all logic on posedge
//   reset  : asynchronous active-low reset, count returns to 0
//   clear  : synchronous clear to 0 (wins over enable)
//   enable : increment by one, holding at all-ones once reached
//   count  : current count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/grid_solve_ctrl.sv
// Sequences one solve of the sudoku grid core per host request.
// A request is accepted in IDLE, the grid is held in reset for CLEAR_CYCLES
// cycles, given a one-cycle start pulse, then watched in RUN until it
// finishes, the host aborts, or the optional watchdog expires. The result is
// held in RESPOND until the host takes it.
//   clock        : single clock, posedge
//   reset        : asynchronous active-low reset
//   req_valid/req_ready/req_timeout : solve request (timeout 0 = no limit)
//   abort        : cancel a solve in CLEAR, ARM or RUN
//   rsp_valid/rsp_ready/rsp_status/rsp_cycles : result handshake
//   grid_reset   : synchronous active-high reset to the grid core
//   grid_start   : one-cycle start pulse to the grid core
//   grid_done    : grid core finished (level)
//   grid_success : grid core solved, meaningful while grid_done=1
module grid_solve_ctrl
  import sudoku_ctrl_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_timeout,
  input  logic             abort,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_status,
  output logic [CNT_W-1:0] rsp_cycles,
  output logic             grid_reset,
  output logic             grid_start,
  input  logic             grid_done,
  input  logic             grid_success
);

  // The CLEAR down-counter runs from CLEAR_CYCLES-1 to 0, so it only needs
  // enough bits to hold CLEAR_CYCLES-1.
  localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LOAD = CLR_W'(CLEAR_CYCLES - 1);

  ctrl_state_e       state_q, state_d;
  logic [CNT_W-1:0]  timeout_q, timeout_d;
  logic [CLR_W-1:0]  clear_cnt_q, clear_cnt_d;
  solve_status_e     status_q, status_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;

  logic              run_clear;
  logic              run_enable;
  logic [CNT_W-1:0]  run_count;
  logic [CNT_W-1:0]  run_inc;
  logic              timeout_hit;

  // RUN cycle counter; cleared when a request is accepted.
  sat_counter #(
    .W (CNT_W)
  ) u_run_cnt (
    .clock  (clock),
    .reset  (reset),
    .clear  (run_clear),
    .enable (run_enable),
    .count  (run_count)
  );

  assign run_enable = (state_q == ST_RUN);

  // run_count holds completed RUN cycles, so the cycle being evaluated now is
  // run_count+1 (saturating). That is both the reported count on exit and the
  // value the watchdog limit is compared against.
  assign run_inc     = (run_count == '1) ? run_count : run_count + CNT_W'(1);
  assign timeout_hit = (timeout_q != '0) && (run_inc == timeout_q);

  always_comb begin
    state_d     = state_q;
    timeout_d   = timeout_q;
    clear_cnt_d = clear_cnt_q;
    status_d    = status_q;
    cycles_d    = cycles_q;
    run_clear   = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        state_d = ST_IDLE;
      end

      ST_IDLE: begin
        if (req_valid) begin
          timeout_d   = req_timeout;
          clear_cnt_d = CLR_LOAD;
          run_clear   = 1'b1;
          state_d     = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        if (abort) begin
          status_d = STATUS_ABORTED;
          cycles_d = '0;
          state_d  = ST_RESPOND;
        end else if (clear_cnt_q == '0) begin
          state_d = ST_ARM;
        end else begin
          clear_cnt_d = clear_cnt_q - CLR_W'(1);
        end
      end

      ST_ARM: begin
        if (abort) begin
          status_d = STATUS_ABORTED;
          cycles_d = '0;
          state_d  = ST_RESPOND;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // Priority order matters: a finish on the same cycle as the watchdog
        // limit reports the grid's verdict rather than TIMEOUT.
        if (abort) begin
          status_d = STATUS_ABORTED;
          cycles_d = run_inc;
          state_d  = ST_RESPOND;
        end else if (grid_done) begin
          status_d = grid_success ? STATUS_SUCCESS : STATUS_FAILURE;
          cycles_d = run_inc;
          state_d  = ST_RESPOND;
        end else if (timeout_hit) begin
          status_d = STATUS_TIMEOUT;
          cycles_d = run_inc;
          state_d  = ST_RESPOND;
        end
      end

      ST_RESPOND: begin
        // The grid is left alone here; its done level persists until the
        // next CLEAR.
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      timeout_q   <= '0;
      clear_cnt_q <= '0;
      status_q    <= STATUS_SUCCESS;
      cycles_q    <= '0;
    end else begin
      state_q     <= state_d;
      timeout_q   <= timeout_d;
      clear_cnt_q <= clear_cnt_d;
      status_q    <= status_d;
      cycles_q    <= cycles_d;
    end
  end

  // All handshake and grid outputs decode from the state register only.
  assign req_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESPOND);
  assign grid_reset = (state_q == ST_INIT) || (state_q == ST_CLEAR);
  assign grid_start = (state_q == ST_ARM);
  assign rsp_status = status_q;
  assign rsp_cycles = cycles_q;

endmodule
